sddr_bank_scheduler: RTL and testbench
======================================

// Module: sddr_bank_scheduler
// PURPOSE
//  Open-page DDR3 command scheduler: tracks the open row of every bank, issues ACT/RD/WR/PRE/REF under
//  tRCD/tRP/tRAS/tCCD/tRFC timing, and manages refresh with a postponement budget.
//  Sits in the DDR clock domain between the CDC'd data command path and the PHY command pins.
//  Generalises the single-bank auto-precharge sequencer to 2**BANK_BITS banks kept open across requests.
// PARAMETERS
//  BANK_BITS     3     bank address width; NBANKS = 2**BANK_BITS
//  ROW_BITS      13    row address width
//  COL_BITS      10    column address width (<=10; A10 reserved for precharge/auto-precharge)
//  tRCD          6     ACT to RD/WR, cycles
//  tRP           6     PRE to ACT/REF, cycles
//  tRAS          15    ACT to PRE same bank, cycles
//  tCCD          4     RD/WR to next RD/WR, cycles
//  tRFC          88    REF to any command, cycles
//  tREFI         6240  refresh interval, cycles
//  MAX_POSTPONE  8     refresh credits allowed to accumulate before refresh is forced
// PORTS
//  ddr_clock_i      in   1            DDR command clock
//  reset_i          in   1            asynchronous, active-high reset
//  req_valid_i      in   1            request present; fields stable while valid && !ready
//  req_write_i      in   1            1=write, 0=read
//  req_bank_i       in   BANK_BITS    target bank
//  req_row_i        in   ROW_BITS     target row
//  req_col_i        in   COL_BITS     target column
//  req_ready_o      out  1            one-cycle pulse: request consumed (its RD/WR issued next edge)
//  ddr3_cmd_o       out  4            {CS,RAS,CAS,WE}, registered
//  ddr3_ba_o        out  BANK_BITS    registered bank
//  ddr3_addr_o      out  ROW_BITS     registered address
//  data_issue_o     out  1            1 in the cycle RD/WR is on ddr3_cmd_o
//  data_write_o     out  1            qualifies data_issue_o: 1 = WR
//  refresh_busy_o   out  1            high from PRE-all decision until tRFC after REF expires
//  open_banks_o     out  NBANKS       bit b = bank b has an open row
// BEHAVIOUR
//  Encodings: NOP 0111, ACT 0011, RD 0101, WR 0100, PRE 0010, REF 0001. At most one command per cycle.
//  Reset (async): ddr3_cmd_o=NOP, ba/addr=0, req_ready_o=0, data_issue_o=0, data_write_o=0,
//   refresh_busy_o=0, open_banks_o=0; all timers 0, credits 0, tREFI counter reloaded to tREFI.
//  Per bank: open flag, open row, tRAS timer (loaded on ACT), tRP timer (loaded on PRE), tRCD timer (on ACT).
//  Global: tCCD timer (on RD/WR), tRFC timer, tREFI down-counter, credit counter 0..MAX_POSTPONE.
//  Timers load value N => dependent command legal N cycles after the loading command, never earlier.
//  Request decision, bank b=req_bank_i, when no refresh is active:
//   - closed, tRP done -> ACT ba=b addr=row; set open, record row.
//   - open, row hit, tRCD and tCCD done -> RD/WR ba=b addr={0,A10=0,col}; req_ready_o=1 that cycle.
//   - open, row miss, tRAS done -> PRE ba=b A10=0; clear open. Then ACT after tRP, then RD/WR.
//   - otherwise NOP and wait; request is never dropped, reordered or issued twice.
//  Refresh: tREFI counter hits 0 -> reload, credit+1 (saturating at MAX_POSTPONE).
//   Start refresh if credit==MAX_POSTPONE (forced, pre-empts waiting request) or credit>0 && !req_valid_i.
//   Once started: req_ready_o=0; PRE-all (A10=1) when every open bank's tRAS done (skip if none open),
//   REF after tRP, credit-1, refresh_busy_o clears tRFC cycles after REF. All banks closed after.
//   Same-cycle tREFI expiry and REF issue: credit unchanged net.
//  A started refresh is never abandoned; a request arriving mid-refresh waits.
//  open_banks_o and timers update at the edge the command is registered.
//  Reset mid-operation: all state abandoned; outputs NOP immediately; after release, banks assumed closed.
// TESTING (params: tRCD=2 tRP=2 tRAS=5 tCCD=4 tRFC=10 tREFI=100 MAX_POSTPONE=2)
//  1 Read bank 2 row 5 col 8, all closed -> ACT ba=2 addr=5, RD ba=2 addr=8 exactly 2 cycles later,
//    one req_ready_o pulse, data_issue_o=1 with RD, open_banks_o=8'h04.
//  2 Four back-to-back reads bank 2 row 5 -> RDs spaced exactly 4 cycles, no extra ACT/PRE.
//  3 Row 5 open (ACT at t), read row 9 -> PRE ba=2 at >=t+5, ACT addr=9 at PRE+2, RD at ACT+2.
//  4 Idle, banks 0,3 open -> at cycle 100 PRE-all (A10=1), REF 2 cycles later, no command for 10 cycles,
//    open_banks_o=0, refresh_busy_o high throughout.
//  5 Continuous hit traffic -> no refresh at cycle 100; forced at cycle 200 (credit=2); req_ready_o low
//    from PRE-all to REF+10; traffic then resumes with a new ACT.
//  6 reset_i pulsed 1 cycle after ACT -> ddr3_cmd_o=NOP same cycle, no RD follows, open_banks_o=0;
//    after release the pending request re-issues ACT.

Source files
------------

// File: rtl/sddr_bank_scheduler.sv
// Open-page DDR3 command scheduler: per-bank open-row tracking, ACT/RD/WR/PRE/REF issue under
// tRCD/tRP/tRAS/tCCD/tRFC, and refresh postponement with a bounded credit budget.
module sddr_bank_scheduler #(
    parameter int BANK_BITS    = 3,
    parameter int ROW_BITS     = 13,
    parameter int COL_BITS     = 10,
    parameter int tRCD         = 6,
    parameter int tRP          = 6,
    parameter int tRAS         = 15,
    parameter int tCCD         = 4,
    parameter int tRFC         = 88,
    parameter int tREFI        = 6240,
    parameter int MAX_POSTPONE = 8
) (
    input  logic                  ddr_clock_i,
    input  logic                  reset_i,
    input  logic                  req_valid_i,
    input  logic                  req_write_i,
    input  logic [BANK_BITS-1:0]  req_bank_i,
    input  logic [ROW_BITS-1:0]   req_row_i,
    input  logic [COL_BITS-1:0]   req_col_i,
    output logic                  req_ready_o,
    output logic [3:0]            ddr3_cmd_o,
    output logic [BANK_BITS-1:0]  ddr3_ba_o,
    output logic [ROW_BITS-1:0]   ddr3_addr_o,
    output logic                  data_issue_o,
    output logic                  data_write_o,
    output logic                  refresh_busy_o,
    output logic [2**BANK_BITS-1:0] open_banks_o
);

    localparam int NBANKS = 2**BANK_BITS;
    localparam int RCD_W  = $clog2(tRCD + 1);
    localparam int RP_W   = $clog2(tRP + 1);
    localparam int RAS_W  = $clog2(tRAS + 1);
    localparam int CCD_W  = $clog2(tCCD + 1);
    localparam int RFC_W  = $clog2(tRFC + 1);
    localparam int REFI_W = $clog2(tREFI + 1);
    localparam int CRD_W  = $clog2(MAX_POSTPONE + 1);

    typedef enum logic [3:0] {
        CMD_REF = 4'b0001,
        CMD_PRE = 4'b0010,
        CMD_ACT = 4'b0011,
        CMD_WR  = 4'b0100,
        CMD_RD  = 4'b0101,
        CMD_NOP = 4'b0111
    } cmd_e;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_PRE,
        RF_REF,
        RF_RFC
    } rf_state_e;

    rf_state_e             rf_q, rf_d;
    cmd_e                  cmd_q, cmd_d;
    logic [BANK_BITS-1:0]  ba_q, ba_d;
    logic [ROW_BITS-1:0]   addr_q, addr_d;
    logic                  issue_q, write_q;
    logic                  busy_q, busy_d;
    logic [NBANKS-1:0]     open_q;
    logic [ROW_BITS-1:0]   row_q  [NBANKS];
    logic [RAS_W-1:0]      tras_q [NBANKS];
    logic [RP_W-1:0]       trp_q  [NBANKS];
    logic [RCD_W-1:0]      trcd_q [NBANKS];
    logic [CCD_W-1:0]      tccd_q;
    logic [RFC_W-1:0]      trfc_q;
    logic [REFI_W-1:0]     refi_q;
    logic [CRD_W-1:0]      credit_q;

    logic                  do_act, do_pre, do_pre_all, do_rdwr, do_ref;
    logic                  tras_all_done, trp_all_done;
    logic                  expire, credit_inc, start;
    logic [CRD_W-1:0]      credit_eff;

    assign ddr3_cmd_o     = cmd_q;
    assign ddr3_ba_o      = ba_q;
    assign ddr3_addr_o    = addr_q;
    assign data_issue_o   = issue_q;
    assign data_write_o   = write_q;
    assign refresh_busy_o = busy_q;
    assign open_banks_o   = open_q;

    // An expiry in this cycle already counts, so refresh can be decided on the expiring cycle.
    assign expire     = (refi_q == REFI_W'(1));
    assign credit_inc = expire && (credit_q != CRD_W'(MAX_POSTPONE));
    assign credit_eff = credit_q + CRD_W'(credit_inc);
    assign start      = (rf_q == RF_IDLE) &&
                        ((credit_eff == CRD_W'(MAX_POSTPONE)) ||
                         ((credit_eff != '0) && !req_valid_i));

    always_comb begin
        tras_all_done = 1'b1;
        trp_all_done  = 1'b1;
        for (int unsigned i = 0; i < NBANKS; i++) begin
            if (open_q[i] && (tras_q[i] != '0)) tras_all_done = 1'b0;
            if (trp_q[i] != '0) trp_all_done = 1'b0;
        end
    end

    always_comb begin
        rf_d        = rf_q;
        cmd_d       = CMD_NOP;
        ba_d        = '0;
        addr_d      = '0;
        busy_d      = busy_q;
        req_ready_o = 1'b0;
        do_act      = 1'b0;
        do_pre      = 1'b0;
        do_pre_all  = 1'b0;
        do_rdwr     = 1'b0;
        do_ref      = 1'b0;
        case (rf_q)
            RF_IDLE, RF_PRE: begin
                if ((rf_q == RF_PRE) || start) begin
                    busy_d = 1'b1;
                    if (open_q == '0) begin
                        rf_d = RF_REF;
                    end else if (tras_all_done) begin
                        cmd_d      = CMD_PRE;
                        addr_d[10] = 1'b1;
                        do_pre_all = 1'b1;
                        rf_d       = RF_REF;
                    end else begin
                        rf_d = RF_PRE;
                    end
                end else if (req_valid_i) begin
                    if (!open_q[req_bank_i]) begin
                        if (trp_q[req_bank_i] == '0) begin
                            cmd_d  = CMD_ACT;
                            ba_d   = req_bank_i;
                            addr_d = req_row_i;
                            do_act = 1'b1;
                        end
                    end else if (row_q[req_bank_i] == req_row_i) begin
                        if ((trcd_q[req_bank_i] == '0) && (tccd_q == '0)) begin
                            cmd_d                  = req_write_i ? CMD_WR : CMD_RD;
                            ba_d                   = req_bank_i;
                            addr_d[COL_BITS-1:0]   = req_col_i;
                            do_rdwr                = 1'b1;
                            req_ready_o            = 1'b1;
                        end
                    end else if (tras_q[req_bank_i] == '0) begin
                        cmd_d  = CMD_PRE;
                        ba_d   = req_bank_i;
                        do_pre = 1'b1;
                    end
                end
            end
            RF_REF: begin
                if (trp_all_done) begin
                    cmd_d  = CMD_REF;
                    do_ref = 1'b1;
                    rf_d   = RF_RFC;
                end
            end
            RF_RFC: begin
                if (trfc_q == '0) begin
                    rf_d   = RF_IDLE;
                    busy_d = 1'b0;
                end
            end
            default: rf_d = RF_IDLE;
        endcase
    end

    always_ff @(posedge ddr_clock_i or posedge reset_i) begin
        if (reset_i) begin
            rf_q     <= RF_IDLE;
            cmd_q    <= CMD_NOP;
            ba_q     <= '0;
            addr_q   <= '0;
            issue_q  <= 1'b0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            open_q   <= '0;
            tccd_q   <= '0;
            trfc_q   <= '0;
            refi_q   <= REFI_W'(tREFI);
            credit_q <= '0;
            for (int unsigned i = 0; i < NBANKS; i++) begin
                row_q[i]  <= '0;
                tras_q[i] <= '0;
                trp_q[i]  <= '0;
                trcd_q[i] <= '0;
            end
        end else begin
            rf_q    <= rf_d;
            cmd_q   <= cmd_d;
            ba_q    <= ba_d;
            addr_q  <= addr_d;
            issue_q <= do_rdwr;
            write_q <= do_rdwr && req_write_i;
            busy_q  <= busy_d;

            // Timers load N-1: the issuing decision sees zero one cycle before the legal edge.
            if (do_rdwr)             tccd_q <= CCD_W'(tCCD - 1);
            else if (tccd_q != '0)   tccd_q <= tccd_q - CCD_W'(1);
            if (do_ref)              trfc_q <= RFC_W'(tRFC - 1);
            else if (trfc_q != '0)   trfc_q <= trfc_q - RFC_W'(1);

            refi_q <= expire ? REFI_W'(tREFI) : refi_q - REFI_W'(1);
            if (expire && !do_ref && credit_inc) credit_q <= credit_q + CRD_W'(1);
            else if (do_ref && !expire)           credit_q <= credit_q - CRD_W'(1);

            for (int unsigned i = 0; i < NBANKS; i++) begin
                if (do_pre_all || (do_pre && (req_bank_i == BANK_BITS'(i)))) begin
                    open_q[i] <= 1'b0;
                    trp_q[i]  <= RP_W'(tRP - 1);
                end else if (trp_q[i] != '0) begin
                    trp_q[i] <= trp_q[i] - RP_W'(1);
                end
                if (do_act && (req_bank_i == BANK_BITS'(i))) begin
                    open_q[i] <= 1'b1;
                    row_q[i]  <= req_row_i;
                    tras_q[i] <= RAS_W'(tRAS - 1);
                    trcd_q[i] <= RCD_W'(tRCD - 1);
                end else begin
                    if (tras_q[i] != '0) tras_q[i] <= tras_q[i] - RAS_W'(1);
                    if (trcd_q[i] != '0) trcd_q[i] <= trcd_q[i] - RCD_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sddr_bank_scheduler.sv
// Directed bench for sddr_bank_scheduler: command log with cycle stamps checked against hand timelines.
module tb_sddr_bank_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_bank = '0;
    logic [12:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        ready;
    logic [3:0]  cmd;
    logic [2:0]  ba;
    logic [12:0] addr;
    logic        di, dw, busy;
    logic [7:0]  open_banks;

    sddr_bank_scheduler #(
        .BANK_BITS(3), .ROW_BITS(13), .COL_BITS(10),
        .tRCD(2), .tRP(2), .tRAS(5), .tCCD(4), .tRFC(10), .tREFI(100), .MAX_POSTPONE(2)
    ) dut (
        .ddr_clock_i(clk), .reset_i(rst),
        .req_valid_i(req_valid), .req_write_i(req_write),
        .req_bank_i(req_bank), .req_row_i(req_row), .req_col_i(req_col),
        .req_ready_o(ready), .ddr3_cmd_o(cmd), .ddr3_ba_o(ba), .ddr3_addr_o(addr),
        .data_issue_o(di), .data_write_o(dw), .refresh_busy_o(busy), .open_banks_o(open_banks)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, RD = 4'b0101,
                           WR = 4'b0100, PRE = 4'b0010, REF = 4'b0001;

    typedef struct {
        int         cyc;
        logic [3:0] cmd;
        logic [2:0] ba;
        logic [12:0] addr;
        logic       di;
        logic       dw;
    } ev_t;

    ev_t ev_q[$];
    int  rdy_q[$];
    int  cyc;
    int  n_cmp = 0;
    int  n_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (cmd != NOP) ev_q.push_back('{cyc, cmd, ba, addr, di, dw});
            if (ready) rdy_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic ev_t get_ev(input int i);
        ev_t e;
        e = '{-1, 4'h0, 3'h0, 13'h0, 1'b0, 1'b0};
        if (i < ev_q.size()) e = ev_q[i];
        return e;
    endfunction

    task automatic check_ev(input string tag, input int i, input int c, input logic [3:0] k,
                            input logic [2:0] b, input logic [12:0] a);
        ev_t e;
        e = get_ev(i);
        check({tag, "_cyc"},  e.cyc,  c);
        check({tag, "_cmd"},  {28'h0, e.cmd}, {28'h0, k});
        check({tag, "_ba"},   {29'h0, e.ba},  {29'h0, b});
        check({tag, "_addr"}, {19'h0, e.addr}, {19'h0, a});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ev_q.delete();
        rdy_q.delete();
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic send(input logic w, input int b, input int r, input int c);
        int  n;
        bit  got;
        req_write = w;
        req_bank  = 3'(b);
        req_row   = 13'(r);
        req_col   = 10'(c);
        req_valid = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            if (ready) got = 1'b1;
            n++;
        end
        if (!got) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int first;
        ev_t e;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd",   {28'h0, cmd}, {28'h0, NOP});
        check("rst_ba",    {29'h0, ba}, 32'h0);
        check("rst_addr",  {19'h0, addr}, 32'h0);
        check("rst_ready", {31'h0, ready}, 32'h0);
        check("rst_issue", {31'h0, di}, 32'h0);
        check("rst_write", {31'h0, dw}, 32'h0);
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_open",  {24'h0, open_banks}, 32'h0);

        // 1: closed bank read, then 2: four back-to-back hits
        do_reset();
        send(1'b0, 2, 5, 8);
        wait_until(4);
        check_ev("t1_act", 0, 1, ACT, 3'd2, 13'd5);
        check_ev("t1_rd",  1, 3, RD,  3'd2, 13'd8);
        e = get_ev(1);
        check("t1_rd_issue", {31'h0, e.di}, 32'h1);
        check("t1_rd_write", {31'h0, e.dw}, 32'h0);
        e = get_ev(0);
        check("t1_act_issue", {31'h0, e.di}, 32'h0);
        check("t1_ready_cnt", rdy_q.size(), 1);
        check("t1_open", {24'h0, open_banks}, 32'h04);
        for (int i = 0; i < 4; i++) send(1'b0, 2, 5, i);
        wait_until(21);
        check("t2_size", ev_q.size(), 6);
        for (int i = 0; i < 4; i++)
            check_ev($sformatf("t2_rd%0d", i), 2 + i, 7 + 4 * i, RD, 3'd2, 13'(i));

        // 3: row miss -> PRE, ACT, WR
        do_reset();
        send(1'b0, 2, 5, 8);
        send(1'b1, 2, 9, 'h2A);
        wait_until(12);
        check("t3_size", ev_q.size(), 5);
        check_ev("t3_pre", 2, 6, PRE, 3'd2, 13'h000);
        check_ev("t3_act", 3, 8, ACT, 3'd2, 13'd9);
        check_ev("t3_wr",  4, 10, WR, 3'd2, 13'h2A);
        e = get_ev(4);
        check("t3_wr_issue", {31'h0, e.di}, 32'h1);
        check("t3_wr_write", {31'h0, e.dw}, 32'h1);
        check("t3_open", {24'h0, open_banks}, 32'h04);

        // 4: idle refresh with banks 0 and 3 open
        do_reset();
        send(1'b0, 0, 1, 0);
        send(1'b0, 3, 2, 0);
        wait_until(50);
        check("t4_open_pre", {24'h0, open_banks}, 32'h09);
        check("t4_busy_idle", {31'h0, busy}, 32'h0);
        wait_until(100);
        check("t4_busy_start", {31'h0, busy}, 32'h1);
        wait_until(111);
        check("t4_busy_end", {31'h0, busy}, 32'h1);
        check("t4_open_ref", {24'h0, open_banks}, 32'h0);
        wait_until(112);
        check("t4_busy_clear", {31'h0, busy}, 32'h0);
        wait_until(120);
        check("t4_size", ev_q.size(), 6);
        check_ev("t4_rd3",  3, 7, RD, 3'd3, 13'd0);
        check_ev("t4_prea", 4, 100, PRE, 3'd0, 13'h400);
        check_ev("t4_ref",  5, 102, REF, 3'd0, 13'h000);

        // 5: continuous hit traffic, forced refresh at cycle 200
        do_reset();
        begin
            int col;
            col = 0;
            while (cyc < 240) begin
                send(1'b0, 1, 7, col & 'h3FF);
                col++;
            end
        end
        check_ev("t5_act", 0, 1, ACT, 3'd1, 13'd7);
        cnt = 0;
        for (int i = 1; i <= 50; i++) begin
            e = get_ev(i);
            if (e.cmd == RD && e.cyc == 3 + 4 * (i - 1)) cnt++;
        end
        check("t5_rd_train", cnt, 50);
        check_ev("t5_prea", 51, 200, PRE, 3'd0, 13'h400);
        check_ev("t5_ref",  52, 202, REF, 3'd0, 13'h000);
        check_ev("t5_react", 53, 213, ACT, 3'd1, 13'd7);
        e = get_ev(54);
        check("t5_rd_after_cyc", e.cyc, 215);
        check("t5_rd_after_cmd", {28'h0, e.cmd}, {28'h0, RD});
        cnt = 0;
        first = -1;
        foreach (rdy_q[i]) begin
            if (rdy_q[i] >= 199 && rdy_q[i] <= 212) cnt++;
            if (first < 0 && rdy_q[i] > 198) first = rdy_q[i];
        end
        check("t5_ready_blocked", cnt, 0);
        check("t5_ready_resume", first, 214);

        // 6: reset right after ACT
        do_reset();
        req_write = 1'b0;
        req_bank  = 3'd4;
        req_row   = 13'd3;
        req_col   = 10'd1;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        check("t6_act_seen", {28'h0, cmd}, {28'h0, ACT});
        check("t6_open_before", {24'h0, open_banks}, 32'h10);
        rst = 1'b1;
        #1;
        check("t6_cmd_nop", {28'h0, cmd}, {28'h0, NOP});
        check("t6_open_clr", {24'h0, open_banks}, 32'h0);
        check("t6_ready_low", {31'h0, ready}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ev_q.delete();
        rdy_q.delete();
        check("t6_open_rel", {24'h0, open_banks}, 32'h0);
        wait_until(5);
        req_valid = 1'b0;
        check_ev("t6_react", 0, 1, ACT, 3'd4, 13'd3);
        check_ev("t6_rd",    1, 3, RD,  3'd4, 13'd1);
        check("t6_ready_cnt", rdy_q.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
